// File: rtl/se_imem_loader_if.sv
`default_nettype none
// ============================================================================
//  Module      : se_imem_loader_if
//  Description : Bundles the instruction word stream (data/valid/ready) and
//                the instruction-memory load port (loadData/loadAddr/wrEn)
//                used by se_imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface se_imem_loader_if;
    // Instruction word stream from the boot/debug side
    logic [31:0] data;
    logic        valid;
    logic        ready;

    // Instruction-memory load port
    logic [31:0] loadData;
    logic [63:0] loadAddr;
    logic        wrEn;

    // Boot/debug side: drives the stream and watches the memory writes
    modport master (
        output data,
        output valid,
        input  ready,
        input  loadData,
        input  loadAddr,
        input  wrEn
    );

    // Loader side: consumes the stream and drives the memory writes
    modport slave (
        input  data,
        input  valid,
        output ready,
        output loadData,
        output loadAddr,
        output wrEn
    );
endinterface
`default_nettype wire

// File: rtl/se_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : se_imem_loader
//  Description : Sequencing controller for the instruction-memory load port.
//                Accepts a stream of 32-bit words and writes them to
//                consecutive word addresses starting at a latched base, while
//                holding the core in reset until the image is complete.
//                Optional feature macro: SE_IMEM_LOADER_CHECKSUM_EN
//                (adds a trailing checksum word verified in CHECK state).
//  Revision    : 1.0 - initial release
// ============================================================================
module se_imem_loader #(
    parameter int MAX_WORDS = 1024,
    parameter int CNT_W     = 16
) (
    input  wire logic             clk_i,
    input  wire logic             rst_n_i,
    input  wire logic             start_i,
    input  wire logic [63:0]      baseAddr_i,
    input  wire logic [CNT_W-1:0] wordCount_i,
    se_imem_loader_if.slave       bus,
    output logic                  coreRst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WORDS);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd2,
`endif
        ST_DONE  = 3'd3,
        ST_ERROR = 3'd4
    } state_t;

`ifdef SE_IMEM_LOADER_CHECKSUM_EN
    // Image completion goes through the checksum word first
    localparam state_t ST_IMAGE_END = ST_CHECK;
`else
    localparam state_t ST_IMAGE_END = ST_DONE;
`endif

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] index_q,     index_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [63:0]      wr_addr_q,   wr_addr_d;
    logic             ready_q,     ready_d;
    logic             wr_en_q,     wr_en_d;
    logic [31:0]      load_data_q, load_data_d;
    logic [63:0]      load_addr_q, load_addr_d;
    logic             core_rst_n_q, core_rst_n_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic             err_q,       err_d;
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
    logic [31:0]      sum_q,       sum_d;
`endif

    logic start_ok;
    logic accept;
    logic last_word;

    // Next-state, datapath and registered-output computation
    always_comb begin
        state_d      = state_q;
        index_d      = index_q;
        count_d      = count_q;
        wr_addr_d    = wr_addr_q;
        wr_en_d      = 1'b0;
        load_data_d  = load_data_q;
        load_addr_d  = load_addr_q;
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
        sum_d        = sum_q;
`endif
        // A start is only honoured while no load is in flight
        start_ok  = start_i && ((state_q == ST_IDLE) || (state_q == ST_DONE) ||
                                (state_q == ST_ERROR));
        accept    = bus.valid && ready_q;
        last_word = (index_q == (count_q - CNT_W'(1)));

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (start_i) begin
                    count_d   = wordCount_i;
                    wr_addr_d = baseAddr_i;
                    index_d   = '0;
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
                    sum_d     = '0;
`endif
                    if ((baseAddr_i[1:0] != 2'b00) || (wordCount_i > MAX_CNT)) begin
                        state_d = ST_ERROR;
                    end else if (wordCount_i == '0) begin
                        state_d = ST_IMAGE_END;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end
            end

            ST_LOAD: begin
                if (accept) begin
                    wr_en_d     = 1'b1;
                    load_data_d = bus.data;
                    load_addr_d = wr_addr_q;
                    // Word addresses advance by 4 and wrap modulo 2^64
                    wr_addr_d   = wr_addr_q + 64'd4;
                    index_d     = index_q + CNT_W'(1);
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
                    sum_d       = sum_q + bus.data;
`endif
                    if (last_word) begin
                        state_d = ST_IMAGE_END;
                    end
                end
            end

`ifdef SE_IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                // The trailing word is compared only, never written
                if (accept) begin
                    state_d = (bus.data == sum_q) ? ST_DONE : ST_ERROR;
                end
            end
`endif

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status outputs are registered images of the upcoming state
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
        ready_d = (state_d == ST_LOAD) || (state_d == ST_CHECK);
`else
        ready_d = (state_d == ST_LOAD);
`endif
        busy_d = ready_d;
        err_d  = (state_d == ST_ERROR);
        // Restarting from DONE counts as a fresh entry into DONE
        done_d = (state_d == ST_DONE) && ((state_q != ST_DONE) || start_ok);
        // Core leaves reset one cycle after DONE is entered, so the last
        // memory write always lands first; any accepted start re-asserts it
        core_rst_n_d = (state_q == ST_DONE) && (state_d == ST_DONE) && !start_ok;
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q      <= ST_IDLE;
            index_q      <= '0;
            count_q      <= '0;
            wr_addr_q    <= '0;
            ready_q      <= 1'b0;
            wr_en_q      <= 1'b0;
            load_data_q  <= '0;
            load_addr_q  <= '0;
            core_rst_n_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
            sum_q        <= '0;
`endif
        end else begin
            state_q      <= state_d;
            index_q      <= index_d;
            count_q      <= count_d;
            wr_addr_q    <= wr_addr_d;
            ready_q      <= ready_d;
            wr_en_q      <= wr_en_d;
            load_data_q  <= load_data_d;
            load_addr_q  <= load_addr_d;
            core_rst_n_q <= core_rst_n_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
`endif
        end
    end

    assign bus.ready    = ready_q;
    assign bus.wrEn     = wr_en_q;
    assign bus.loadData = load_data_q;
    assign bus.loadAddr = load_addr_q;
    assign coreRst_n_o  = core_rst_n_q;
    assign busy_o       = busy_q;
    assign done_o       = done_q;
    assign err_o        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_se_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_se_imem_loader
//  Description : Self-checking bench for se_imem_loader. Random image words
//                and handshake patterns; expected writes are derived from
//                base + 4*i (mod 2^64) and the observed acceptance cycles.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_se_imem_loader;

    localparam int MAX_WORDS = 1024;
    localparam int CNT_W     = 16;

    logic             clk_i = 1'b0;
    logic             rst_n_i;
    logic             start_i;
    logic [63:0]      baseAddr_i;
    logic [CNT_W-1:0] wordCount_i;
    logic             coreRst_n_o;
    logic             busy_o;
    logic             done_o;
    logic             err_o;

    se_imem_loader_if bus ();

    se_imem_loader #(
        .MAX_WORDS (MAX_WORDS),
        .CNT_W     (CNT_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .start_i     (start_i),
        .baseAddr_i  (baseAddr_i),
        .wordCount_i (wordCount_i),
        .bus         (bus),
        .coreRst_n_o (coreRst_n_o),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t         wlog[$];
    wr_t         mon_w;
    logic [31:0] img[$];
    int          acc[$];

    // Record every memory write seen on the load port
    always @(negedge clk_i) begin
        if (bus.wrEn === 1'b1) begin
            mon_w.addr = bus.loadAddr;
            mon_w.data = bus.loadData;
            mon_w.cyc  = cyc;
            wlog.push_back(mon_w);
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    task automatic start_load(input logic [63:0] base, input logic [CNT_W-1:0] cnt);
        start_i     = 1'b1;
        baseAddr_i  = base;
        wordCount_i = cnt;
        @(negedge clk_i);
        start_i = 1'b0;
        chk("core_rst_after_start", coreRst_n_o, 1'b0);
    endtask

    // mode 0: valid held high, 1: valid every other cycle,
    // 2: random valid plus stray (illegal) start pulses during the load
    task automatic run_load(input logic [63:0] base, input int mode, input bit bad_sum);
        logic [31:0] tx[$];
        logic [31:0] sum;
        int          n;
        int          k;
        int          guard;
        bit          v;
        bit          r;
        bit          good;
        bit          exp_wr;
        n    = img.size();
        tx   = img;
        sum  = 32'd0;
        good = !bad_sum;
        foreach (img[i]) sum += img[i];
`ifdef SE_IMEM_LOADER_CHECKSUM_EN
        tx.push_back(bad_sum ? sum + 32'd1 : sum);
        exp_wr = 1'b0;
`else
        exp_wr = (n > 0);
`endif
        wlog.delete();
        acc.delete();
        start_load(base, CNT_W'(n));
        k     = 0;
        guard = 0;
        while (k < tx.size() && guard < 4000) begin
            r = bus.ready;
            chk("ready_high_in_load", r, 1'b1);
            chk("busy_high_in_load", busy_o, 1'b1);
            if (mode == 0)      v = 1'b1;
            else if (mode == 1) v = (guard % 2 == 0);
            else                v = 1'($urandom_range(0, 1));
            bus.valid = v;
            bus.data  = v ? tx[k] : $urandom;
            if (mode == 2 && $urandom_range(0, 3) == 0) begin
                start_i    = 1'b1;
                baseAddr_i = 64'h3;
            end else begin
                start_i = 1'b0;
            end
            @(negedge clk_i);
            if (v && r) begin
                acc.push_back(cyc - 1);
                k++;
            end
            guard++;
        end
        bus.valid = 1'b0;
        start_i   = 1'b0;
        chk("load_completed_in_budget", k, tx.size());
        chk("ready_low_at_end", bus.ready, 1'b0);
        chk("busy_low_at_end", busy_o, 1'b0);
        chk("done_pulse", done_o, good);
        chk("err_at_end", err_o, !good);
        chk("core_rst_held_at_end", coreRst_n_o, 1'b0);
        chk("wren_at_end", bus.wrEn, exp_wr);
        @(negedge clk_i);
        chk("core_rst_release", coreRst_n_o, good);
        chk("done_one_cycle", done_o, 1'b0);
        chk("err_hold", err_o, !good);
        repeat (2) @(negedge clk_i);
        chk("write_count", wlog.size(), n);
        for (int i = 0; i < n && i < wlog.size() && i < acc.size(); i++) begin
            chk("write_addr", wlog[i].addr, base + 64'(i) * 64'd4);
            chk("write_data", wlog[i].data, img[i]);
            chk("write_cycle", wlog[i].cyc, acc[i] + 1);
        end
    endtask

    task automatic run_bad(input logic [63:0] base, input logic [CNT_W-1:0] cnt);
        wlog.delete();
        start_load(base, cnt);
        chk("bad_err", err_o, 1'b1);
        chk("bad_ready", bus.ready, 1'b0);
        chk("bad_busy", busy_o, 1'b0);
        chk("bad_done", done_o, 1'b0);
        bus.valid = 1'b1;
        bus.data  = $urandom;
        repeat (3) @(negedge clk_i);
        bus.valid = 1'b0;
        chk("bad_err_hold", err_o, 1'b1);
        chk("bad_core_rst", coreRst_n_o, 1'b0);
        chk("bad_no_writes", wlog.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog_timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n_i     = 1'b0;
        start_i     = 1'b0;
        baseAddr_i  = '0;
        wordCount_i = '0;
        bus.valid   = 1'b0;
        bus.data    = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_ready", bus.ready, 1'b0);
        chk("rst_wren", bus.wrEn, 1'b0);
        chk("rst_load_data", bus.loadData, 32'd0);
        chk("rst_load_addr", bus.loadAddr, 64'd0);
        chk("rst_core_rst", coreRst_n_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_done", done_o, 1'b0);
        chk("rst_err", err_o, 1'b0);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("idle_ready", bus.ready, 1'b0);
        chk("idle_core_rst", coreRst_n_o, 1'b0);

        // Basic three-word load, valid held and valid toggling
        img.delete();
        img.push_back(32'hA); img.push_back(32'hB); img.push_back(32'hC);
        run_load(64'h1000, 0, 1'b0);
        run_load(64'h1000, 1, 1'b0);

        // Address wrap past the top of the 64-bit space
        rand_img(3);
        run_load(64'hFFFF_FFFF_FFFF_FFF8, 0, 1'b0);

        // Rejected starts, then recovery
        run_bad(64'h1002, CNT_W'(3));
        run_bad(64'h1000, CNT_W'(MAX_WORDS + 1));
        rand_img(5);
        run_load(64'h4000, 2, 1'b0);

        // Empty image
        img.delete();
        run_load(64'h8000, 0, 1'b0);

        // Reset in the middle of a four-word load
        rand_img(4);
        wlog.delete();
        start_load(64'h2000, CNT_W'(4));
        bus.valid = 1'b1;
        bus.data  = img[0];
        @(negedge clk_i);
        bus.data  = img[1];
        @(negedge clk_i);
        bus.valid = 1'b0;
        #1 rst_n_i = 1'b0;
        #1;
        chk("midrst_ready", bus.ready, 1'b0);
        chk("midrst_wren", bus.wrEn, 1'b0);
        chk("midrst_core_rst", coreRst_n_o, 1'b0);
        chk("midrst_busy", busy_o, 1'b0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        @(negedge clk_i);
        chk("midrst_writes", wlog.size(), 2);
        if (wlog.size() > 1) chk("midrst_addr1", wlog[1].addr, 64'h2004);
        rand_img(4);
        run_load(64'h2000, 0, 1'b0);

        // Largest legal image
        rand_img(MAX_WORDS);
        run_load(64'h0001_0000_0000_0000, 0, 1'b0);

        // Randomised loads
        for (int t = 0; t < 8; t++) begin
            rand_img($urandom_range(1, 9));
            run_load({$urandom, $urandom} & ~64'h3, $urandom_range(0, 2), 1'b0);
        end

`ifdef SE_IMEM_LOADER_CHECKSUM_EN
        // Checksum accepted, then rejected, then recovery
        img.delete();
        img.push_back(32'd1); img.push_back(32'd2); img.push_back(32'd3);
        run_load(64'h1000, 0, 1'b0);
        run_load(64'h1000, 1, 1'b1);
        rand_img(4);
        run_load(64'h3000, 2, 1'b0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
